// File: rtl/stream_serializer.sv
// Width-down serializer: takes DATA_WIDTH words and emits RATIO OUT_WIDTH beats with out_last on the final beat.
// Define SER_MSB_FIRST_EN to emit the most-significant beat first (default is least-significant first).
module stream_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  if (((DATA_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_params
    $error("stream_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH with at least two beats");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    valid_d;
  logic [OUT_WIDTH-1:0]    data_d;
  logic                    last_d;
  logic                    accept;
  logic                    beat_fire;

  function automatic logic [OUT_WIDTH-1:0] beat_of(input logic [DATA_WIDTH-1:0] word,
                                                   input logic [CNT_W-1:0]      idx);
`ifdef SER_MSB_FIRST_EN
    return OUT_WIDTH'(word >> (DATA_WIDTH - OUT_WIDTH - int'(idx) * OUT_WIDTH));
`else
    return OUT_WIDTH'(word >> (int'(idx) * OUT_WIDTH));
`endif
  endfunction

  // A new word may load while the final beat of the previous one is being taken, so there is no bubble.
  assign beat_fire = out_valid & out_ready;
  assign in_ready  = rst_n & ((state_q == IDLE) | (beat_fire & out_last));
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    valid_d = out_valid;
    data_d  = out_data;
    last_d  = out_last;
    if (accept) begin
      state_d = SEND;
      hold_d  = in_data;
      cnt_d   = '0;
      valid_d = 1'b1;
      data_d  = beat_of(in_data, '0);
      last_d  = 1'b0;
    end else if (beat_fire) begin
      if (out_last) begin
        state_d = IDLE;
        valid_d = 1'b0;
        data_d  = '0;
        last_d  = 1'b0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        data_d = beat_of(hold_q, cnt_q + CNT_W'(1));
        last_d = ((cnt_q + CNT_W'(1)) == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer (32-bit words, 8-bit beats); expected beat orders follow SER_MSB_FIRST_EN.
module tb_stream_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  int checks = 0;
  int errors = 0;

`ifdef SER_MSB_FIRST_EN
  localparam logic [7:0] EXP_A  [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  localparam logic [7:0] EXP_B1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  localparam logic [7:0] EXP_B2 [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
  localparam logic [7:0] EXP_C  [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
  localparam logic [7:0] EXP_D  [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
`else
  localparam logic [7:0] EXP_A  [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
  localparam logic [7:0] EXP_B1 [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [7:0] EXP_B2 [4] = '{8'h88, 8'h77, 8'h66, 8'h55};
  localparam logic [7:0] EXP_C  [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
  localparam logic [7:0] EXP_D  [4] = '{8'h04, 8'h03, 8'h02, 8'h01};
`endif

  stream_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Data is only meaningful while a beat is valid, so it is compared only then.
  task automatic checkOutput(input string tag, input logic ev, input logic [7:0] ed,
                             input logic el, input logic er);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".out_last"},  32'(out_last),  32'(el));
    check({tag, ".in_ready"},  32'(in_ready),  32'(er));
    if (ev) check({tag, ".out_data"}, 32'(out_data), 32'(ed));
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
    tick();
    tick();
    checkOutput("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset.out_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    #1;
    check("release.in_ready", 32'(in_ready), 32'h1);
    check("release.out_valid", 32'(out_valid), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();

    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
    check("single.accept_ready", 32'(in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("single", 1'b1, EXP_A[k], k == 3, k == 3);
      tick();
    end
    checkOutput("single_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h11223344, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h55667788, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("b2b_w0", 1'b1, EXP_B1[k], k == 3, k == 3);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("b2b_w1", 1'b1, EXP_B2[k], k == 3, k == 3);
      tick();
    end
    checkOutput("b2b_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bp_beat0", 1'b1, EXP_A[0], 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_hold", 1'b1, EXP_A[1], 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 1; k < 4; k++) begin
      checkOutput("bp_resume", 1'b1, EXP_A[k], k == 3, k == 3);
      tick();
    end
    checkOutput("bp_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'hCAFEF00D, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rst_mid_b0", 1'b1, EXP_C[0], 1'b0, 1'b0);
    tick();
    checkOutput("rst_mid_b1", 1'b1, EXP_C[1], 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_async", 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_mid_async.out_data", 32'(out_data), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_mid_idle", 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h01020304, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("post_rst", 1'b1, EXP_D[k], k == 3, k == 3);
      tick();
    end
    checkOutput("post_rst_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
